// File: rtl/condlogic_pkg.sv
// Shared processor definitions used by the conditional-execution logic:
// the sixteen condition-field encodings and the bit positions of the
// architectural flags inside the 4-bit {N,Z,C,V} vector.
package condlogic_pkg;

   // Condition field encodings (instruction bits [31:28])
   localparam logic [3:0] COND_EQ  = 4'b0000;
   localparam logic [3:0] COND_NE  = 4'b0001;
   localparam logic [3:0] COND_CS  = 4'b0010;
   localparam logic [3:0] COND_CC  = 4'b0011;
   localparam logic [3:0] COND_MI  = 4'b0100;
   localparam logic [3:0] COND_PL  = 4'b0101;
   localparam logic [3:0] COND_VS  = 4'b0110;
   localparam logic [3:0] COND_VC  = 4'b0111;
   localparam logic [3:0] COND_HI  = 4'b1000;
   localparam logic [3:0] COND_LS  = 4'b1001;
   localparam logic [3:0] COND_GE  = 4'b1010;
   localparam logic [3:0] COND_LT  = 4'b1011;
   localparam logic [3:0] COND_GT  = 4'b1100;
   localparam logic [3:0] COND_LE  = 4'b1101;
   localparam logic [3:0] COND_AL  = 4'b1110;
   localparam logic [3:0] COND_UNC = 4'b1111;

   // Flag bit positions inside {N,Z,C,V}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/condlogic_condcheck.sv
// Purely combinational condition evaluator: decides whether an instruction
// with the given condition field executes, based on the architectural flags.
module condcheck
   import condlogic_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic flagN;
   logic flagZ;
   logic flagC;
   logic flagV;

   assign flagN = Flags[FLAG_N];
   assign flagZ = Flags[FLAG_Z];
   assign flagC = Flags[FLAG_C];
   assign flagV = Flags[FLAG_V];

   // Decode the condition field into a single execute/skip decision;
   // AL and the 1111 encoding both execute unconditionally.
   always_comb begin
      CondEx = 1'b1;
      case (Cond)
         COND_EQ:  CondEx = flagZ;
         COND_NE:  CondEx = ~flagZ;
         COND_CS:  CondEx = flagC;
         COND_CC:  CondEx = ~flagC;
         COND_MI:  CondEx = flagN;
         COND_PL:  CondEx = ~flagN;
         COND_VS:  CondEx = flagV;
         COND_VC:  CondEx = ~flagV;
         COND_HI:  CondEx = flagC & ~flagZ;
         COND_LS:  CondEx = ~flagC | flagZ;
         COND_GE:  CondEx = (flagN == flagV);
         COND_LT:  CondEx = (flagN != flagV);
         COND_GT:  CondEx = ~flagZ & (flagN == flagV);
         COND_LE:  CondEx = flagZ | (flagN != flagV);
         COND_AL:  CondEx = 1'b1;
         COND_UNC: CondEx = 1'b1;
         default:  CondEx = 1'b1;
      endcase
   end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution unit: holds the architectural flags, evaluates the
// instruction condition and gates PC, register-file and memory writes with
// the registered condition result.
module condlogic
   import condlogic_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       NextPC,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags,
   output logic       CondEx
);

   logic [1:0] nz_q;
   logic [1:0] nz_d;
   logic [1:0] cv_q;
   logic [1:0] cv_d;
   logic       condExD_q;

   assign Flags = {nz_q, cv_q};

   condcheck u_condcheck (
      .Cond   (Cond),
      .Flags  (Flags),
      .CondEx (CondEx)
   );

   // Each flag pair loads only when its write is requested and the
   // instruction passes its condition, so a skipped instruction leaves flags intact.
   always_comb begin
      nz_d = nz_q;
      cv_d = cv_q;
      if (FlagW[1] && CondEx) begin
         nz_d = ALUFlags[3:2];
      end
      if (FlagW[0] && CondEx) begin
         cv_d = ALUFlags[1:0];
      end
   end

   // Flag registers and the delayed condition result; reset clears them at
   // once so any write gated by the delayed condition is aborted immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nz_q      <= 2'b00;
         cv_q      <= 2'b00;
         condExD_q <= 1'b0;
      end else begin
         nz_q      <= nz_d;
         cv_q      <= cv_d;
         condExD_q <= CondEx;
      end
   end

   assign PCWrite  = (PCS && condExD_q) || NextPC;
   assign RegWrite = RegW && condExD_q;
   assign MemWrite = MemW && condExD_q;

endmodule

// File: tb/tb_condlogic.sv
// Self-checking bench for condlogic: directed scenarios plus a randomized
// run, with expected flags and delayed condition pushed to a scoreboard
// when stimulus is applied and popped after the clock edge.
module tb_condlogic;

   logic       clk;
   logic       reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic [3:0] Flags;
   logic       CondEx;

   typedef struct {
      logic [3:0] flags;
      logic       condExD;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] mFlags;
   logic       mCondExD;
   int         checks = 0;
   int         errors = 0;

   condlogic dut (
      .clk      (clk),
      .reset    (reset),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .PCS      (PCS),
      .NextPC   (NextPC),
      .RegW     (RegW),
      .MemW     (MemW),
      .PCWrite  (PCWrite),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite),
      .Flags    (Flags),
      .CondEx   (CondEx)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference condition evaluation built from the base-condition/invert structure
   function automatic logic condModel(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cf & ~z;
         3'd5:    base = (n == v);
         3'd6:    base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      if (c[3:1] == 3'd7) return 1'b1;
      return c[0] ? ~base : base;
   endfunction

   task automatic idleInputs();
      Cond     = 4'b1110;
      ALUFlags = 4'b0000;
      FlagW    = 2'b00;
      PCS      = 1'b0;
      NextPC   = 1'b0;
      RegW     = 1'b0;
      MemW     = 1'b0;
   endtask

   // Update the model with the current (pre-edge) inputs, record the
   // expectation, then advance past the clock edge
   task automatic applyStimulus();
      logic ce;
      exp_t e;
      ce = condModel(Cond, mFlags);
      if (FlagW[1] && ce) mFlags[3:2] = ALUFlags[3:2];
      if (FlagW[0] && ce) mFlags[1:0] = ALUFlags[1:0];
      mCondExD  = ce;
      e.flags   = mFlags;
      e.condExD = ce;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic loadFlags(input logic [3:0] value);
      exp_t e;
      idleInputs();
      Cond     = 4'b1110;
      FlagW    = 2'b11;
      ALUFlags = value;
      applyStimulus();
      e = sb.pop_front();
      idleInputs();
   endtask

   task automatic test_reset();
      idleInputs();
      reset  = 1'b1;
      NextPC = 1'b1;
      RegW   = 1'b1;
      MemW   = 1'b1;
      PCS    = 1'b1;
      #2;
      checks++; if (Flags !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got %b expected 0000", Flags); end
      checks++; if (PCWrite !== 1'b1) begin errors++; $display("[TB] FAIL reset_pcwrite got %b expected 1", PCWrite); end
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite got %b expected 0", RegWrite); end
      checks++; if (MemWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_memwrite got %b expected 0", MemWrite); end
      NextPC = 1'b0;
      #1;
      checks++; if (PCWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_pcwrite_nonext got %b expected 0", PCWrite); end
      ALUFlags = 4'b1111;
      FlagW    = 2'b11;
      @(posedge clk);
      #1;
      checks++; if (Flags !== 4'b0000) begin errors++; $display("[TB] FAIL reset_hold_flags got %b expected 0000", Flags); end
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold_regwrite got %b expected 0", RegWrite); end
      #2;
      idleInputs();
      reset    = 1'b0;
      mFlags   = 4'b0000;
      mCondExD = 1'b0;
      sb.delete();
   endtask

   task automatic test_flag_load();
      exp_t e;
      idleInputs();
      Cond     = 4'b1110;
      FlagW    = 2'b11;
      ALUFlags = 4'b0100;
      applyStimulus();
      e = sb.pop_front();
      checks++; if (Flags !== 4'b0100) begin errors++; $display("[TB] FAIL load_flags got %b expected 0100", Flags); end
      checks++; if (Flags !== e.flags) begin errors++; $display("[TB] FAIL load_flags_sb got %b expected %b", Flags, e.flags); end
      Cond  = 4'b0000;
      FlagW = 2'b00;
      #1;
      checks++; if (CondEx !== 1'b1) begin errors++; $display("[TB] FAIL load_eq_condex got %b expected 1", CondEx); end
      RegW = 1'b1;
      applyStimulus();
      e = sb.pop_front();
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("[TB] FAIL load_regwrite got %b expected 1", RegWrite); end
      idleInputs();
   endtask

   task automatic test_suppress();
      exp_t e;
      idleInputs();
      Cond     = 4'b0001;
      FlagW    = 2'b11;
      ALUFlags = 4'b1111;
      #1;
      checks++; if (CondEx !== 1'b0) begin errors++; $display("[TB] FAIL suppress_condex got %b expected 0", CondEx); end
      applyStimulus();
      e = sb.pop_front();
      checks++; if (Flags !== 4'b0100) begin errors++; $display("[TB] FAIL suppress_flags got %b expected 0100", Flags); end
      MemW = 1'b1;
      PCS  = 1'b1;
      #1;
      checks++; if (MemWrite !== 1'b0) begin errors++; $display("[TB] FAIL suppress_memwrite got %b expected 0", MemWrite); end
      checks++; if (PCWrite !== 1'b0) begin errors++; $display("[TB] FAIL suppress_pcwrite got %b expected 0", PCWrite); end
      NextPC = 1'b1;
      #1;
      checks++; if (PCWrite !== 1'b1) begin errors++; $display("[TB] FAIL nextpc_force got %b expected 1", PCWrite); end
      idleInputs();
   endtask

   task automatic test_split();
      exp_t e;
      loadFlags(4'b0000);
      Cond     = 4'b1110;
      FlagW    = 2'b10;
      ALUFlags = 4'b1011;
      applyStimulus();
      e = sb.pop_front();
      checks++; if (Flags !== 4'b1000) begin errors++; $display("[TB] FAIL split_nz got %b expected 1000", Flags); end
      FlagW = 2'b01;
      applyStimulus();
      e = sb.pop_front();
      checks++; if (Flags !== 4'b1011) begin errors++; $display("[TB] FAIL split_cv got %b expected 1011", Flags); end
      idleInputs();
   endtask

   task automatic test_signed();
      loadFlags(4'b1001);
      Cond = 4'b1010; #1;
      checks++; if (CondEx !== 1'b1) begin errors++; $display("[TB] FAIL ge_1001 got %b expected 1", CondEx); end
      Cond = 4'b1011; #1;
      checks++; if (CondEx !== 1'b0) begin errors++; $display("[TB] FAIL lt_1001 got %b expected 0", CondEx); end
      Cond = 4'b1100; #1;
      checks++; if (CondEx !== 1'b1) begin errors++; $display("[TB] FAIL gt_1001 got %b expected 1", CondEx); end
      Cond = 4'b1101; #1;
      checks++; if (CondEx !== 1'b0) begin errors++; $display("[TB] FAIL le_1001 got %b expected 0", CondEx); end
      loadFlags(4'b1101);
      Cond = 4'b1100; #1;
      checks++; if (CondEx !== 1'b0) begin errors++; $display("[TB] FAIL gt_1101 got %b expected 0", CondEx); end
      Cond = 4'b1101; #1;
      checks++; if (CondEx !== 1'b1) begin errors++; $display("[TB] FAIL le_1101 got %b expected 1", CondEx); end
      idleInputs();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      loadFlags(4'b0000);
      Cond     = 4'b0001;
      FlagW    = 2'b11;
      ALUFlags = 4'b0100;
      RegW     = 1'b1;
      #1;
      checks++; if (CondEx !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pre_condex got %b expected 1", CondEx); end
      applyStimulus();
      e = sb.pop_front();
      checks++; if (Flags !== 4'b0100) begin errors++; $display("[TB] FAIL b2b_flags got %b expected 0100", Flags); end
      checks++; if (CondEx !== 1'b0) begin errors++; $display("[TB] FAIL b2b_post_condex got %b expected 0", CondEx); end
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("[TB] FAIL b2b_regwrite got %b expected 1", RegWrite); end
      idleInputs();
   endtask

   task automatic test_async_reset();
      exp_t e;
      loadFlags(4'b1111);
      RegW = 1'b1;
      #1;
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_regwrite got %b expected 1", RegWrite); end
      #1 reset = 1'b1;
      #1;
      checks++; if (Flags !== 4'b0000) begin errors++; $display("[TB] FAIL areset_flags got %b expected 0000", Flags); end
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL areset_regwrite got %b expected 0", RegWrite); end
      #1 reset = 1'b0;
      mFlags   = 4'b0000;
      mCondExD = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL areset_post_regwrite got %b expected 0", RegWrite); end
      Cond = 4'b1110;
      applyStimulus();
      e = sb.pop_front();
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("[TB] FAIL areset_first_edge got %b expected 1", RegWrite); end
      checks++; if (Flags !== 4'b0000) begin errors++; $display("[TB] FAIL areset_first_flags got %b expected 0000", Flags); end
      idleInputs();
   endtask

   task automatic test_random();
      exp_t e;
      logic expCe;
      for (int i = 0; i < 80; i++) begin
         Cond     = 4'($urandom_range(0, 15));
         ALUFlags = 4'($urandom_range(0, 15));
         FlagW    = 2'($urandom_range(0, 3));
         PCS      = 1'($urandom_range(0, 1));
         NextPC   = ($urandom_range(0, 3) == 0);
         RegW     = 1'($urandom_range(0, 1));
         MemW     = 1'($urandom_range(0, 1));
         #1;
         expCe = condModel(Cond, mFlags);
         checks++; if (CondEx !== expCe) begin errors++; $display("[TB] FAIL rand_condex cond=%b flags=%b got %b expected %b", Cond, mFlags, CondEx, expCe); end
         applyStimulus();
         e = sb.pop_front();
         checks++; if (Flags !== e.flags) begin errors++; $display("[TB] FAIL rand_flags got %b expected %b", Flags, e.flags); end
         checks++; if (RegWrite !== (RegW & e.condExD)) begin errors++; $display("[TB] FAIL rand_regwrite got %b expected %b", RegWrite, RegW & e.condExD); end
         checks++; if (MemWrite !== (MemW & e.condExD)) begin errors++; $display("[TB] FAIL rand_memwrite got %b expected %b", MemWrite, MemW & e.condExD); end
         checks++; if (PCWrite !== ((PCS & e.condExD) | NextPC)) begin errors++; $display("[TB] FAIL rand_pcwrite got %b expected %b", PCWrite, (PCS & e.condExD) | NextPC); end
      end
      idleInputs();
   endtask

   // Bound the whole run so a stuck simulation still terminates
   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   // Run every scenario in sequence and report the totals
   initial begin
      mFlags   = 4'b0000;
      mCondExD = 1'b0;
      test_reset();
      test_flag_load();
      test_suppress();
      test_split();
      test_signed();
      test_back_to_back();
      test_async_reset();
      test_random();
      checks++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL scoreboard_leftover got %0d expected 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
